// File: rtl/key_conditioner_if.sv
// Key conditioner pin/pulse bundle: raw active-low key pins in, and the
// debounced level plus press/release/repeat pulses out.
interface key_conditioner_if #(
   parameter int NUM_KEYS = 2
);
   logic [NUM_KEYS-1:0] key_n;
   logic [NUM_KEYS-1:0] level;
   logic [NUM_KEYS-1:0] press_pulse;
   logic [NUM_KEYS-1:0] release_pulse;
   logic [NUM_KEYS-1:0] repeat_pulse;

   modport master (
      output key_n,
      input  level, press_pulse, release_pulse, repeat_pulse
   );

   modport slave (
      input  key_n,
      output level, press_pulse, release_pulse, repeat_pulse
   );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchroniser, debounce FSM and auto-repeat generator feeding the
// timer controller; every key channel is an identical, independent copy.
module key_conditioner #(
   parameter int NUM_KEYS        = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic                clk,
   input  logic                reset,
   key_conditioner_if.slave    key_if
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW   = $clog2(HMAX) + 1;

   localparam logic [DW-1:0] DB_LIM     = DW'(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] CNT_ONE    = DW'(1);
   localparam logic [HW-1:0] DELAY_LIM  = HW'(REPEAT_DELAY);
   localparam logic [HW-1:0] PERIOD_LIM = HW'(REPEAT_PERIOD);
   localparam bit            DB_ONE     = (DEBOUNCE_CYCLES == 1);
   localparam bit            RPT_ON     = (REPEAT_EN != 0);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic          s1_q, sync_q;
      state_t        state_q, state_d;
      logic [DW-1:0] cnt_q, cnt_d, cnt_inc;
      logic [HW-1:0] hold_q, hold_d, hold_inc, hold_lim;
      logic          periodic_q, periodic_d;
      logic          level_q, level_d;
      logic          press_q, press_d;
      logic          rel_q, rel_d;
      logic          rep_q, rep_d;

      // Two-flop synchroniser; idles high so reset looks like a released key.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            s1_q   <= 1'b1;
            sync_q <= 1'b1;
         end else begin
            s1_q   <= key_if.key_n[gi];
            sync_q <= s1_q;
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state_q    <= RELEASED;
            cnt_q      <= '0;
            hold_q     <= '0;
            periodic_q <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            rep_q      <= 1'b0;
         end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            periodic_q <= periodic_d;
            level_q    <= level_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            rep_q      <= rep_d;
         end
      end

      always_comb begin
         state_d    = state_q;
         cnt_d      = cnt_q;
         hold_d     = hold_q;
         periodic_d = periodic_q;
         rep_d      = 1'b0;
         cnt_inc    = (cnt_q >= DB_LIM) ? DB_LIM : cnt_q + 1'b1;
         hold_inc   = (hold_q == {HW{1'b1}}) ? hold_q : hold_q + 1'b1;
         hold_lim   = periodic_q ? PERIOD_LIM : DELAY_LIM;

         // cnt counts consecutive stable samples including the current one,
         // so the change is accepted on the sample that makes it reach the limit.
         case (state_q)
            RELEASED: begin
               cnt_d = '0;
               if (!sync_q) begin
                  state_d = DB_ONE ? PRESSED : PRESS_WAIT;
                  cnt_d   = DB_ONE ? '0 : CNT_ONE;
               end
            end
            PRESS_WAIT: begin
               if (sync_q) begin
                  state_d = RELEASED;
                  cnt_d   = '0;
               end else if (cnt_inc >= DB_LIM) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            PRESSED: begin
               cnt_d = '0;
               if (RPT_ON) begin
                  if (hold_inc >= hold_lim) begin
                     rep_d      = 1'b1;
                     hold_d     = '0;
                     periodic_d = 1'b1;
                  end else begin
                     hold_d = hold_inc;
                  end
               end
               if (sync_q) begin
                  state_d = DB_ONE ? RELEASED : RELEASE_WAIT;
                  cnt_d   = DB_ONE ? '0 : CNT_ONE;
               end
            end
            RELEASE_WAIT: begin
               if (!sync_q) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else if (cnt_inc >= DB_LIM) begin
                  state_d = RELEASED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = RELEASED;
               cnt_d   = '0;
            end
         endcase

         press_d = (state_q == RELEASED || state_q == PRESS_WAIT) && (state_d == PRESSED);
         rel_d   = (state_q == PRESSED || state_q == RELEASE_WAIT) && (state_d == RELEASED);
         level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);

         // A fresh press restarts the hold timer; a bounce back from RELEASE_WAIT does not.
         if (press_d) begin
            hold_d     = '0;
            periodic_d = 1'b0;
         end
      end

      assign key_if.level[gi]         = level_q;
      assign key_if.press_pulse[gi]   = press_q;
      assign key_if.release_pulse[gi] = rel_q;
      assign key_if.repeat_pulse[gi]  = rep_q;
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: expected pulse events are queued as
// stimulus is applied and checked cycle by cycle on the falling clock edge.
module tb_key_conditioner;

   logic clk;
   logic reset;
   int   edge_cnt = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   e;
   int   p;
   int   rep_at[5] = '{10, 13, 16, 19, 22};

   typedef struct {
      int         at_edge;
      logic [1:0] press;
      logic [1:0] rel;
      logic [1:0] rep;
   } ev_t;

   ev_t sb[$];

   key_conditioner_if #(.NUM_KEYS(2)) if0 ();
   key_conditioner_if #(.NUM_KEYS(2)) if1 ();

   assign if1.key_n = if0.key_n;

   key_conditioner #(
      .NUM_KEYS(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
      .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut0 (
      .clk(clk), .reset(reset), .key_if(if0.slave)
   );

   key_conditioner #(
      .NUM_KEYS(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
      .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut1 (
      .clk(clk), .reset(reset), .key_if(if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, edge_cnt, obs, exp);
      end
   endtask

   task automatic push(input int at, input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] rp);
      ev_t ev;
      ev.at_edge = at;
      ev.press   = pr;
      ev.rel     = rl;
      ev.rep     = rp;
      sb.push_back(ev);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_level(input string tag, input logic [1:0] exp);
      chk({tag, "_lvl0"}, if0.level, exp);
      chk({tag, "_lvl1"}, if1.level, exp);
   endtask

   // Every cycle: pulses must match the queued events for this edge, else be zero.
   logic [1:0] exp_p, exp_r, exp_t;
   ev_t        ev_m;
   always @(negedge clk) begin
      exp_p = 2'b00;
      exp_r = 2'b00;
      exp_t = 2'b00;
      while (sb.size() > 0 && sb[0].at_edge <= edge_cnt) begin
         ev_m  = sb.pop_front();
         exp_p = exp_p | ev_m.press;
         exp_r = exp_r | ev_m.rel;
         exp_t = exp_t | ev_m.rep;
         $display("edge %0d: expect press=%b release=%b repeat=%b", edge_cnt, ev_m.press, ev_m.rel, ev_m.rep);
      end
      chk("press0",   if0.press_pulse,   exp_p);
      chk("release0", if0.release_pulse, exp_r);
      chk("repeat0",  if0.repeat_pulse,  exp_t);
      chk("press1",   if1.press_pulse,   exp_p);
      chk("release1", if1.release_pulse, exp_r);
      chk("repeat1",  if1.repeat_pulse,  2'b00);
   end

   initial begin
      reset     = 1'b0;
      if0.key_n = 2'b11;
      step(2);
      chk_level("reset", 2'b00);
      reset = 1'b1;
      step(3);

      // Clean press of key 0, then clean release.
      e = edge_cnt;
      if0.key_n = 2'b10;
      push(e + 6, 2'b01, 2'b00, 2'b00);
      step(5);
      chk_level("t1_pre", 2'b00);
      step(1);
      chk_level("t1_press", 2'b01);
      step(2);
      e = edge_cnt;
      if0.key_n = 2'b11;
      push(e + 6, 2'b00, 2'b01, 2'b00);
      step(5);
      chk_level("t1_relpre", 2'b01);
      step(1);
      chk_level("t1_rel", 2'b00);
      step(3);

      // Bounce: 3 low, 1 high, then steady low.
      if0.key_n = 2'b10;
      step(3);
      if0.key_n = 2'b11;
      step(1);
      e = edge_cnt;
      if0.key_n = 2'b10;
      push(e + 6, 2'b01, 2'b00, 2'b00);
      step(5);
      chk_level("t2_pre", 2'b00);
      step(1);
      chk_level("t2_press", 2'b01);

      // Two-cycle release glitch while pressed, then steady release.
      step(1);
      if0.key_n = 2'b11;
      step(2);
      if0.key_n = 2'b10;
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk_level("t3_glitch", 2'b01);
      end
      e = edge_cnt;
      if0.key_n = 2'b11;
      push(e + 6, 2'b00, 2'b01, 2'b00);
      step(5);
      chk_level("t3_relpre", 2'b01);
      step(1);
      chk_level("t3_rel", 2'b00);
      step(3);

      // Long hold: repeats at hold counts 10,13,16,19,22 (none on the REPEAT_EN=0 copy).
      e = edge_cnt;
      if0.key_n = 2'b10;
      p = e + 6;
      push(p, 2'b01, 2'b00, 2'b00);
      foreach (rep_at[i]) push(p + rep_at[i], 2'b00, 2'b00, 2'b01);
      step(6 + 21);
      chk_level("t4_hold", 2'b01);
      if0.key_n = 2'b11;
      push(p + 27, 2'b00, 2'b01, 2'b00);
      step(6);
      chk_level("t4_rel", 2'b00);
      step(3);

      // Both keys together, then key 1 released alone.
      e = edge_cnt;
      if0.key_n = 2'b00;
      push(e + 6, 2'b11, 2'b00, 2'b00);
      step(6);
      chk_level("t5_both", 2'b11);
      e = edge_cnt;
      if0.key_n = 2'b10;
      push(e + 6, 2'b00, 2'b10, 2'b00);
      push(e + 7, 2'b00, 2'b01, 2'b00);
      step(1);
      if0.key_n = 2'b11;
      step(5);
      chk_level("t5_key1rel", 2'b01);
      step(1);
      chk_level("t5_key0rel", 2'b00);
      step(3);

      // Asynchronous reset in PRESS_WAIT with the key held.
      if0.key_n = 2'b10;
      step(3);
      #2 reset = 1'b0;
      #1;
      chk_level("t6_rst_pw", 2'b00);
      chk("t6_rst_pw_press", if0.press_pulse, 2'b00);
      @(negedge clk);
      reset = 1'b1;
      e = edge_cnt;
      push(e + 6, 2'b01, 2'b00, 2'b00);
      step(5);
      chk_level("t6_redeb_pre", 2'b00);
      step(1);
      chk_level("t6_redeb", 2'b01);

      // Asynchronous reset in PRESSED with the key held.
      step(2);
      #2 reset = 1'b0;
      #1;
      chk_level("t6_rst_pr", 2'b00);
      chk("t6_rst_pr_press", if0.press_pulse, 2'b00);
      chk("t6_rst_pr_rel", if0.release_pulse, 2'b00);
      chk("t6_rst_pr_rep", if0.repeat_pulse, 2'b00);
      @(negedge clk);
      reset = 1'b1;
      e = edge_cnt;
      push(e + 6, 2'b01, 2'b00, 2'b00);
      step(5);
      chk_level("t6_redeb2_pre", 2'b00);
      step(1);
      chk_level("t6_redeb2", 2'b01);
      e = edge_cnt;
      if0.key_n = 2'b11;
      push(e + 6, 2'b00, 2'b01, 2'b00);
      step(6);
      chk_level("t6_rel", 2'b00);
      step(4);

      vectors++;
      assert (sb.size() === 0) else begin
         miscompares++;
         $error("FAIL sb_drain: observed=%0d pending expected=0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions the raw active-low push-button inputs (KEY[2:1]) before they reach the timer controller's set and start/stop inputs.
- Per key: synchronises, debounces, and produces a clean level plus single-cycle press, release and auto-repeat pulses.
- Sits directly upstream of the timer controller. All keys are handled independently by identical per-key logic.

Parameters:
- NUM_KEYS, 2: number of independent key channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable synced samples required to accept a change (20 ms at 50 MHz); must be >= 1.
- REPEAT_EN, 1: 1 enables auto-repeat pulses; 0 holds repeat_pulse low permanently.
- REPEAT_DELAY, 25000000: cycles in PRESSED before the first repeat pulse; must be >= 1.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses; must be >= 1.

Ports:
- clk  input  1  system clock (CLOCK_50).
- reset  input  1  asynchronous, active-low reset (KEY[0]).
- key_n  input  NUM_KEYS  raw button pins, active-low (0 = pressed), asynchronous to clk.
- level  output  NUM_KEYS  debounced key state, active-high (1 = pressed).
- press_pulse  output  NUM_KEYS  one-cycle pulse when a press is accepted.
- release_pulse  output  NUM_KEYS  one-cycle pulse when a release is accepted.
- repeat_pulse  output  NUM_KEYS  one-cycle auto-repeat pulse while held.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is named clk and reset port is named reset.
- Reset (reset=0, asynchronous):
  - synchroniser flops set to 1 (released);
  - every channel enters RELEASED with all counters at 0;
  - level, press_pulse, release_pulse and repeat_pulse are all 0.
  - Reset asserted mid-debounce or mid-hold discards all progress and emits no pulses.
- Synchroniser: 2 flops per key. Edge 0 is the first clk edge that samples key_n low into stage 1; stage 2 (sync) is low after edge 1.
- Per-key FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. A debounce counter holds values 0..DEBOUNCE_CYCLES.
  - RELEASED: sync low -> PRESS_WAIT, count=1 (at edge 2). Otherwise count=0.
  - PRESS_WAIT:
    - sync high -> RELEASED, count=0, no pulse;
    - sync low and count==DEBOUNCE_CYCLES -> PRESSED, count=0;
    - otherwise count+1.
    - PRESSED is therefore entered at edge DEBOUNCE_CYCLES+1. For DEBOUNCE_CYCLES=1 the transition occurs at edge 2 directly.
  - PRESSED: sync high -> RELEASE_WAIT, count=1.
  - RELEASE_WAIT:
    - sync low -> PRESSED, no new press_pulse;
    - sync high and count==DEBOUNCE_CYCLES -> RELEASED;
    - otherwise count+1.
- Outputs are registered:
  - level=1 exactly when the state is PRESSED or RELEASE_WAIT.
  - press_pulse is 1 for the single cycle following the PRESS_WAIT->PRESSED transition edge; level rises on the same edge.
  - release_pulse is 1 for the single cycle following the RELEASE_WAIT->RELEASED transition edge; level falls on the same edge.
- Auto-repeat (REPEAT_EN=1):
  - The hold counter resets to 0 on entry to PRESSED from PRESS_WAIT.
  - It increments each cycle in PRESSED and freezes during RELEASE_WAIT. A bounce back to PRESSED resumes from the frozen value.
  - The first repeat_pulse occurs when hold reaches REPEAT_DELAY. The counter then reloads, and further pulses occur every REPEAT_PERIOD cycles while in PRESSED.
  - No repeat_pulse occurs in the same cycle as press_pulse. Counters saturate and never wrap.
- Channels are fully independent; simultaneous presses give simultaneous pulses on each bit.
- Counter widths are $clog2 of the relevant parameter + 1. Arithmetic is unsigned.

Test Plan:
- (DEBOUNCE_CYCLES=4) Reset, then key_n[0]=0 held at edge 0 -> press_pulse[0]=1 only in the cycle after edge 5; level[0]=1 from edge 5; key 1 outputs stay 0.
- (DEBOUNCE_CYCLES=4) Bounce: key_n[0] low for 3 cycles, high for 1, then low steadily -> no pulse during the bounce; one press_pulse 6 edges after the final low edge.
- (DEBOUNCE_CYCLES=4) Release with a glitch while PRESSED: key_n high for 2 cycles then low -> no release_pulse and no second press_pulse; level stays 1. A steady high then gives release_pulse after 6 edges.
- (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3) Hold for 25 cycles after press_pulse -> repeat_pulse at hold counts 10, 13, 16, 19, 22. With REPEAT_EN=0, repeat_pulse stays 0.
- Both keys pressed on the same edge -> press_pulse=2'b11 in the same cycle. Releasing only key 1 -> release_pulse=2'b10, level=2'b01.
- Reset asserted mid-PRESS_WAIT and mid-PRESSED (asynchronously, between edges) -> all outputs 0 immediately. After release of reset with the key still held low, a full new debounce is required before press_pulse.
